activation_lut_loader: RTL and testbench

- Writer side of the neuron activation lookup table: accepts a byte stream over a valid/ready handshake and fills a 2^ADDR_WIDTH-entry table sequentially from address 0.
- The same table is read through a registered lookup port with one-cycle latency.
- Sits between the configuration/DMA path and the neuron units, so activation functions are loaded at run time instead of from a fixed init file.

---
 rtl/activation_lut_loader.sv | 138 +++++++++++++
 tb/tb_activation_lut_loader.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/activation_lut_loader.sv
// Activation LUT loader: fills a 2^ADDR_WIDTH x DATA_WIDTH table from a byte stream
// and serves one-cycle registered lookups. Optional macro LUT_CHECKSUM_EN adds load checksum verification.
module activation_lut_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_ready,
  output logic                  ld_done,
  output logic                  busy,
  output logic                  table_valid,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
`ifdef LUT_CHECKSUM_EN
  input  logic [15:0]           ld_checksum,
  output logic                  ld_err,
`endif
  output logic [1:0]            dbg_state
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic                    wr_fire;
  logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];

  // Load handshake: a beat transfers on a rising edge where ld_valid && ld_ready.
  // ld_ready is high exactly in LOAD; a load_start in the same cycle wins and the beat is dropped.
  assign ld_ready  = (state == LOAD);
  assign busy      = (state == LOAD);
  assign wr_fire   = ld_ready && ld_valid && !load_start;
  assign dbg_state = state;

`ifdef LUT_CHECKSUM_EN
  logic [15:0] csum_run;
  logic [15:0] csum_ref;
  logic [15:0] csum_next;

  assign csum_next = csum_run + 16'(ld_data);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      ld_done     <= 1'b0;
      table_valid <= 1'b0;
`ifdef LUT_CHECKSUM_EN
      csum_run    <= '0;
      csum_ref    <= '0;
      ld_err      <= 1'b0;
`endif
    end else begin
      ld_done <= 1'b0;
`ifdef LUT_CHECKSUM_EN
      ld_err  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (load_start) begin
            state       <= LOAD;
            wr_ptr      <= '0;
            table_valid <= 1'b0;
`ifdef LUT_CHECKSUM_EN
            csum_run    <= '0;
            csum_ref    <= ld_checksum;
`endif
          end
        end
        LOAD: begin
          if (load_start) begin
            wr_ptr   <= '0;
`ifdef LUT_CHECKSUM_EN
            csum_run <= '0;
            csum_ref <= ld_checksum;
`endif
          end else if (ld_valid) begin
            wr_ptr <= wr_ptr + 1'b1;
`ifdef LUT_CHECKSUM_EN
            csum_run <= csum_next;
`endif
            if (wr_ptr == LAST_ADDR) begin
              state   <= DONE;
              ld_done <= 1'b1;
`ifdef LUT_CHECKSUM_EN
              ld_err  <= (csum_next != csum_ref);
`endif
            end
          end
        end
        DONE: begin
          // load_start is deliberately ignored here; the table commits first.
          state <= IDLE;
`ifdef LUT_CHECKSUM_EN
          table_valid <= (csum_run == csum_ref);
`else
          table_valid <= 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage has no reset so it maps onto a simple dual-port RAM.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= table_valid ? mem[rd_addr] : '0;
      end
    end
  end

endmodule

// File: tb/tb_activation_lut_loader.sv
// Bench for activation_lut_loader at ADDR_WIDTH=4: scenario tasks plus a read scoreboard.
module tb_activation_lut_loader;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          load_start;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          ld_done;
  logic          busy;
  logic          table_valid;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [1:0]    dbg_state;
`ifdef LUT_CHECKSUM_EN
  logic [15:0]   ld_checksum;
  logic          ld_err;
`endif

  activation_lut_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_start  (load_start),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .ld_done     (ld_done),
    .busy        (busy),
    .table_valid (table_valid),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
`ifdef LUT_CHECKSUM_EN
    .ld_checksum (ld_checksum),
    .ld_err      (ld_err),
`endif
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  int            vectors = 0;
  int            miscompares = 0;
  int            done_cnt = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model_mem[DEPTH];
  bit            model_valid;
  int            model_ptr;
  logic [DW-1:0] exp_rd;

  // Scoreboard: compare each rd_valid cycle against the oldest outstanding read
  always @(negedge clk) begin
    if (ld_done === 1'b1) done_cnt++;
    if (rd_valid === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL rd_unexpected: rd_valid=1 with no read outstanding, rd_data=%h", rd_data);
      end else begin
        exp_rd = exp_q.pop_front();
        if (rd_data !== exp_rd) begin
          miscompares++;
          $display("FAIL rd_data: got %h expected %h", rd_data, exp_rd);
        end
      end
    end
  end

  // Driver tasks (all called at a falling edge, return at a falling edge)
  task automatic start_load();
    load_start = 1'b1;
    @(negedge clk);
    load_start  = 1'b0;
    model_valid = 1'b0;
    model_ptr   = 0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d);
    int n;
    ld_valid = 1'b1;
    ld_data  = d;
    n = 0;
    while (ld_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      vectors++;
      miscompares++;
      $display("FAIL beat_timeout: ld_ready=%b never rose, expected 1", ld_ready);
    end else begin
      @(negedge clk);
      model_mem[model_ptr] = d;
      model_ptr = (model_ptr + 1) % DEPTH;
    end
    ld_valid = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    rd_en   = 1'b1;
    rd_addr = a;
    exp_q.push_back(model_valid ? model_mem[a] : '0);
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) do_read(AW'(i));
    @(negedge clk);
  endtask

  task automatic test_reset();
    vectors++;
    if ({ld_ready, ld_done, busy, table_valid, rd_valid} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags: ready/done/busy/tv/rdv=%b expected 00000",
               {ld_ready, ld_done, busy, table_valid, rd_valid});
    end
    vectors++;
    if (rd_data !== '0 || dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_state: rd_data=%h state=%0d expected 00 / 0", rd_data, dbg_state);
    end
    do_read(AW'(5));
    @(negedge clk);
  endtask

  task automatic test_full_load();
    start_load();
    vectors++;
    if (busy !== 1'b1 || ld_ready !== 1'b1 || table_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL load_enter: busy=%b ready=%b tv=%b expected 1 1 0", busy, ld_ready, table_valid);
    end
    for (int i = 0; i < DEPTH; i++) begin
      send_beat(DW'(i * 3));
      if (i < DEPTH - 1) begin
        vectors++;
        if (ld_done !== 1'b0 || busy !== 1'b1) begin
          miscompares++;
          $display("FAIL load_mid: beat %0d done=%b busy=%b expected 0 1", i, ld_done, busy);
        end
      end
    end
    vectors++;
    if (ld_done !== 1'b1 || busy !== 1'b0 || ld_ready !== 1'b0 || table_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL done_cycle: done=%b busy=%b ready=%b tv=%b expected 1 0 0 0",
               ld_done, busy, ld_ready, table_valid);
    end
    @(negedge clk);
    vectors++;
    if (ld_done !== 1'b0 || table_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL after_done: done=%b tv=%b expected 0 1", ld_done, table_valid);
    end
    model_valid = 1'b1;
    do_read(AW'(15));
    do_read(AW'(0));
    read_all();
  endtask

  task automatic test_stalled_load();
    start_load();
    for (int i = 0; i < DEPTH; i++) begin
      send_beat(DW'(i * 3));
      if (i < DEPTH - 1) begin
        repeat ($urandom_range(1, 3)) begin
          vectors++;
          if (busy !== 1'b1 || ld_done !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_hold: busy=%b done=%b expected 1 0", busy, ld_done);
          end
          @(negedge clk);
        end
      end
    end
    vectors++;
    if (ld_done !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_done: done=%b expected 1", ld_done);
    end
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    vectors++;
    if (busy !== 1'b0 || table_valid !== 1'b1 || dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL start_in_done: busy=%b tv=%b state=%0d expected 0 1 0", busy, table_valid, dbg_state);
    end
    model_valid = 1'b1;
    read_all();
    vectors++;
    if (rd_data !== model_mem[DEPTH-1]) begin
      miscompares++;
      $display("FAIL rd_hold: rd_data=%h expected %h", rd_data, model_mem[DEPTH-1]);
    end
  endtask

  task automatic test_abort_restart();
    int cnt0;
    cnt0 = done_cnt;
    start_load();
    for (int i = 0; i < 7; i++) send_beat(8'hFF);
    ld_valid   = 1'b1;
    ld_data    = 8'hEE;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    ld_valid   = 1'b0;
    model_ptr  = 0;
    vectors++;
    if (busy !== 1'b1 || table_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL restart: busy=%b tv=%b expected 1 0", busy, table_valid);
    end
    for (int i = 0; i < DEPTH; i++) send_beat(8'hA5);
    vectors++;
    if (ld_done !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_done: done=%b expected 1", ld_done);
    end
    @(negedge clk);
    model_valid = 1'b1;
    read_all();
    vectors++;
    if (done_cnt - cnt0 !== 1) begin
      miscompares++;
      $display("FAIL done_pulses: got %0d expected 1", done_cnt - cnt0);
    end
  endtask

  task automatic test_reset_mid_load();
    start_load();
    for (int i = 0; i < 9; i++) send_beat(8'h5A);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || table_valid !== 1'b0 || ld_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: busy=%b tv=%b ready=%b expected 0 0 0", busy, table_valid, ld_ready);
    end
    model_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_read(AW'(3));
    ld_valid = 1'b1;
    ld_data  = 8'h77;
    repeat (3) begin
      vectors++;
      if (ld_ready !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_valid: ready=%b busy=%b expected 0 0", ld_ready, busy);
      end
      @(negedge clk);
    end
    ld_valid = 1'b0;
    @(negedge clk);
  endtask

`ifdef LUT_CHECKSUM_EN
  task automatic test_checksum();
    ld_checksum = 16'h0100;
    start_load();
    for (int i = 0; i < DEPTH; i++) send_beat(8'h10);
    vectors++;
    if (ld_done !== 1'b1 || ld_err !== 1'b0) begin
      miscompares++;
      $display("FAIL csum_ok: done=%b err=%b expected 1 0", ld_done, ld_err);
    end
    @(negedge clk);
    vectors++;
    if (table_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL csum_ok_tv: tv=%b expected 1", table_valid);
    end
    model_valid = 1'b1;
    do_read(AW'(7));
    ld_checksum = 16'h0101;
    start_load();
    for (int i = 0; i < DEPTH; i++) send_beat(8'h10);
    vectors++;
    if (ld_done !== 1'b1 || ld_err !== 1'b1) begin
      miscompares++;
      $display("FAIL csum_bad: done=%b err=%b expected 1 1", ld_done, ld_err);
    end
    @(negedge clk);
    vectors++;
    if (ld_err !== 1'b0 || table_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL csum_bad_tv: err=%b tv=%b expected 0 0", ld_err, table_valid);
    end
    model_valid = 1'b0;
    do_read(AW'(7));
    do_read(AW'(0));
    @(negedge clk);
  endtask
`endif

  initial begin
    rst_n      = 1'b0;
    load_start = 1'b0;
    ld_valid   = 1'b0;
    ld_data    = '0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    model_valid = 1'b0;
    model_ptr   = 0;
`ifdef LUT_CHECKSUM_EN
    ld_checksum = '0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    test_reset();
    test_full_load();
    test_stalled_load();
    test_abort_restart();
    test_reset_mid_load();
`ifdef LUT_CHECKSUM_EN
    test_checksum();
`endif

    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rd_missing: %0d reads never returned, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
